// File: rtl/barrel_scaler_pipe.sv
`default_nettype none
// ============================================================================
// Module      : barrel_scaler_pipe
// Description : Pipelined power-of-two scaler for two's-complement samples.
//               Each accepted sample is multiplied by 2^n (left shift) or
//               divided by 2^n (arithmetic right shift). SHW register stages,
//               stage k applies a shift of 2^k when bit k of n is set.
//               Throughput one sample per cycle; a single global advance
//               enable freezes the whole pipe while the output is stalled.
// Ports       : clk, rst            rising-edge clock, async active-high reset
//               in_valid / in_ready input handshake (in_ready = advance)
//               x, shift_n, mode    sample, shift amount, operating mode
//                                   (00 left-wrap, 01 left-sat,
//                                    10 right-floor, 11 right-round)
//               out_valid/out_ready output handshake
//               y, overflow         scaled result, left-shift overflow flag
// Revision    : 1.0  initial release
// ============================================================================
module barrel_scaler_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [SHW-1:0]   shift_n,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             overflow
);

    // All stages move together; nothing moves while the output is held.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S    = 1 << k;
        // Bits that must agree for a left shift by S to be lossless.
        localparam int TOPW = (S + 1 > WIDTH) ? WIDTH : S + 1;
        // Bit that falls just below the binary point on a right shift by S;
        // beyond the word it is a copy of the sign.
        localparam int RB   = (S > WIDTH) ? WIDTH - 1 : S - 1;
        localparam bit LAST = (k == SHW - 1);

        // Stage inputs. The shift amount shrinks by one bit per stage: each
        // stage consumes its own bit and forwards the rest.
        logic [WIDTH-1:0] a_val;
        logic             a_vld;
        logic [1:0]       a_mode;
        logic [SHW-k-1:0] a_n;
        logic             a_sign;
        logic             a_ovf;
        logic             a_rnd;

        logic [WIDTH-1:0] val_d, val_q;
        logic             ovf_d, ovf_q;
        logic             rnd_d;
        logic             vld_q;
        logic [TOPW-1:0]  w_top;

        if (k == 0) begin : g_src
            assign a_val  = x;
            assign a_vld  = in_valid;
            assign a_mode = mode;
            assign a_n    = shift_n;
            assign a_sign = x[WIDTH-1];
            assign a_ovf  = 1'b0;
            assign a_rnd  = 1'b0;
        end else begin : g_chain
            assign a_val  = g_stage[k-1].val_q;
            assign a_vld  = g_stage[k-1].vld_q;
            assign a_mode = g_stage[k-1].g_meta.mode_q;
            assign a_n    = g_stage[k-1].g_meta.n_q;
            assign a_sign = g_stage[k-1].g_meta.sign_q;
            assign a_ovf  = g_stage[k-1].ovf_q;
            assign a_rnd  = g_stage[k-1].g_meta.rnd_q;
        end

        assign w_top = a_val[WIDTH-1 -: TOPW];

        always_comb begin
            val_d = a_val;
            ovf_d = a_ovf;
            rnd_d = a_rnd;
            if (a_n[0]) begin
                if (!a_mode[1]) begin
                    if (S >= WIDTH) begin
                        // Every bit leaves the word: any nonzero value is lost.
                        val_d = '0;
                        ovf_d = a_ovf | (a_val != '0);
                    end else begin
                        val_d = a_val << S;
                        ovf_d = a_ovf | !((&w_top) | ~(|w_top));
                    end
                end else begin
                    val_d = $signed(a_val) >>> S;
                    rnd_d = a_val[RB];
                end
            end
            if (LAST) begin
                if (a_mode == 2'b01 && ovf_d) begin
                    val_d = a_sign ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
                end else if (a_mode == 2'b11) begin
                    // Floor result plus the last bit shifted out gives
                    // round-half-up; the floor magnitude leaves headroom.
                    val_d = val_d + {{(WIDTH-1){1'b0}}, rnd_d};
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                val_q <= '0;
                ovf_q <= 1'b0;
                vld_q <= 1'b0;
            end else if (adv) begin
                val_q <= val_d;
                ovf_q <= ovf_d;
                vld_q <= a_vld;
            end
        end

        // Side-band fields are only needed by later stages.
        if (!LAST) begin : g_meta
            logic [1:0]       mode_q;
            logic [SHW-k-2:0] n_q;
            logic             sign_q;
            logic             rnd_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mode_q <= '0;
                    n_q    <= '0;
                    sign_q <= 1'b0;
                    rnd_q  <= 1'b0;
                end else if (adv) begin
                    mode_q <= a_mode;
                    n_q    <= a_n[SHW-k-1:1];
                    sign_q <= a_sign;
                    rnd_q  <= rnd_d;
                end
            end
        end
    end

    assign out_valid = g_stage[SHW-1].vld_q;
    assign y         = g_stage[SHW-1].val_q;
    assign overflow  = g_stage[SHW-1].ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_scaler_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_scaler_pipe
// Description : Self-checking bench for barrel_scaler_pipe (WIDTH=8, SHW=4):
//               directed vectors, latency, random streaming with
//               backpressure against an arithmetic model, mid-stream reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_barrel_scaler_pipe;

    localparam int WIDTH = 8;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [SHW-1:0]   shift_n;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    barrel_scaler_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .shift_n   (shift_n),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .overflow  (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Arithmetic reference: exact product / quotient, then wrap, saturate
    // or round as the mode dictates. Returns {overflow, y}.
    function automatic logic [8:0] model(input logic [7:0] xv,
                                         input logic [3:0] nv,
                                         input logic [1:0] mv);
        longint     r;
        int         t;
        logic [7:0] yv;
        logic       ov;
        ov = 1'b0;
        if (!mv[1]) begin
            r  = longint'($signed(xv)) * (longint'(1) << nv);
            ov = (r > 127) || (r < -128);
            yv = r[7:0];
            if (mv == 2'b01 && ov) yv = xv[7] ? 8'h80 : 8'h7F;
        end else begin
            t = int'($signed(xv));
            if (mv == 2'b11 && nv != 4'd0) t = t + (1 << (nv - 4'd1));
            t  = t >>> nv;
            yv = t[7:0];
        end
        return {ov, yv};
    endfunction

    // One isolated sample through an empty pipe: latency, y, overflow.
    task automatic run_one(input string tag, input logic [7:0] xv,
                           input logic [3:0] nv, input logic [1:0] mv,
                           input logic [7:0] ey, input logic ev);
        int lat;
        @(negedge clk);
        x = xv; shift_n = nv; mode = mv; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_lat"}, lat, SHW);
        check_val({tag, "_y"}, y, ey);
        check_val({tag, "_ovf"}, overflow, ev);
        @(posedge clk);
    endtask

    initial begin
        int         sent, recv, acc;
        logic [8:0] expq[$];
        logic [8:0] e, held;
        logic       stall_prev, stale;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; shift_n = '0; mode = '0;
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_y", y, 0);
        check_val("rst_ovf", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_ready", in_ready, 1);

        // Directed vectors
        run_one("l0_n1",  8'hF1, 4'd1,  2'b00, 8'hE2, 1'b0);
        run_one("l0_n3",  8'hF1, 4'd3,  2'b00, 8'h88, 1'b0);
        run_one("l0_n4",  8'hF1, 4'd4,  2'b00, 8'h10, 1'b1);
        run_one("l0_n9",  8'hF1, 4'd9,  2'b00, 8'h00, 1'b1);
        run_one("l1_neg", 8'hF1, 4'd4,  2'b01, 8'h80, 1'b1);
        run_one("l1_pos", 8'h0F, 4'd4,  2'b01, 8'h7F, 1'b1);
        run_one("l0_n0",  8'h7F, 4'd0,  2'b00, 8'h7F, 1'b0);
        run_one("rf_n2",  8'hF1, 4'd2,  2'b10, 8'hFC, 1'b0);
        run_one("rr_n2",  8'hF2, 4'd2,  2'b11, 8'hFD, 1'b0);
        run_one("rr_m1",  8'hFF, 4'd15, 2'b11, 8'h00, 1'b0);
        run_one("rf_m1",  8'hFF, 4'd15, 2'b10, 8'hFF, 1'b0);
        run_one("rr_half",8'h05, 4'd1,  2'b11, 8'h03, 1'b0);
        run_one("rr_n0",  8'hF1, 4'd0,  2'b11, 8'hF1, 1'b0);

        // Random streaming with backpressure
        sent = 0; recv = 0; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 2000 && recv < 20; cyc++) begin
            @(negedge clk);
            if (stall_prev)
                check_val("hold", {out_valid, overflow, y}, {1'b1, held});
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                x        = 8'($urandom);
                shift_n  = 4'($urandom);
                mode     = 2'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check_val("extra_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check_val("stream", {overflow, y}, e);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(x, shift_n, mode));
                sent++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {overflow, y};
        end
        check_val("stream_count", recv, 20);
        check_val("stream_left", expq.size(), 0);

        // Fill the pipe under stall, then reset mid-stream
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        x = 8'hF1; shift_n = 4'd4; mode = 2'b00;
        acc = 0;
        for (int c = 0; c < 10 && acc < 4; c++) begin
            #1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("pre_rst_valid", out_valid, 1);
        check_val("pre_rst_y", y, 8'h10);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_y", y, 0);
        check_val("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check_val("no_stale", stale, 0);
        run_one("post_rst", 8'h03, 4'd2, 2'b00, 8'h0C, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
